mem_loader: RTL and testbench
=============================

Name: mem_loader

Overview:
- Write-side counterpart of the synchronous byte ROM/RAM read port.
- Accepts a byte stream over a valid/ready handshake from an SD, SPI-flash or UART front end.
- Writes the bytes to sequential addresses of a KB-kilobyte memory image, paced by a clock-enable strobe.
- Signals completion and reports a running 8-bit checksum. Used at boot to fill ROM/RAM images before the CPU is released.

Parameters:
- KB, 16, memory size in kilobytes; address width AW = $clog2(KB*1024).

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- ce  in  1  write-pacing enable; a memory write may only be issued on an edge where ce=1.
- start  in  1  begin a load; honoured only in IDLE or DONE.
- in_valid  in  1  in_data holds a byte.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can take a byte this cycle.
- a  out  AW  memory write address (registered).
- d  out  8  memory write data (registered).
- we  out  1  memory write strobe, one clock wide (registered). The memory write port samples we every clock, not gated by ce.
- busy  out  1  state is LOAD.
- done  out  1  state is DONE.
- sum  out  8  modulo-256 sum of all bytes written since the last start.

Behaviour:
- Reset values: state IDLE; in_ready=0, a=0, d=0, we=0, busy=0, done=0, sum=0; byte buffer empty; internal address counter addr=0.
- States: IDLE, LOAD, DONE.
- IDLE/DONE + start=1 -> LOAD. On that edge: addr<=0, sum<=0, buffer cleared, done<=0.
- start in LOAD is ignored.
- One-byte buffer (buf, full flag).
- in_ready = (state==LOAD) && !full. It is combinational from registered state only and never depends on in_valid.
- Accept: on an edge with in_valid && in_ready: buf<=in_data, full<=1.
- Write: on an edge with state==LOAD && full && ce, all of the following happen:
  - we<=1, a<=addr, d<=buf;
  - sum<=sum+buf (modulo 256);
  - full<=0, addr<=addr+1.
- On every other edge, we<=0. a and d hold their last values.
- No accept can occur on the write edge, because in_ready is 0 while full. Peak throughput is one byte per 2 clocks.
- ce low with full=1: the byte is held indefinitely, and in_ready stays 0 (backpressure).
- Termination: if a write edge has addr == KB*1024-1, state<=DONE on that same edge. addr wraps to 0 but is unused.
  - busy falls and done rises on the same edge that raises we for the last byte.
  - in_ready=0 in DONE; any further stream bytes are not accepted.
- DONE holds done=1 and sum until a new start or reset.
- Reset mid-LOAD: immediate return to IDLE with reset values. A buffered byte is discarded. A we pulse issued on the edge before reset is not retracted. we=0 from the reset edge on.
- Reset has priority over start and over accept/write on the same edge.
- busy = (state==LOAD); done = (state==DONE). Both are registered-state decodes.

Test Plan:
- Reset check: assert reset for 3 clocks with in_valid=1 -> in_ready=0, we=0, a=0, busy=0, done=0, sum=0 throughout.
- Full load, KB=1, ce=1 always:
  - Stimulus: start pulse, then stream bytes (i*7)&0xFF for i=0..1023 with in_valid held high.
  - Required: exactly 1024 we pulses; pulse n carries a=n, d=(n*7)&0xFF; no two consecutive clocks have we=1.
  - Required: done rises on the edge of the 1024th we; sum equals the modulo-256 sum of the stream; in_ready=0 afterwards.
- ce pacing: ce high one clock in 4, bytes always valid -> we only on edges where ce=1; in_ready low while a byte waits for ce; no byte lost or duplicated over 64 bytes.
- Source stalls: in_valid toggled randomly with a fixed seed over 100 bytes -> addresses strictly consecutive 0..99; data matches the stream order; busy=1, done=0.
- Reset mid-load: reset after 10 writes with one byte buffered -> state IDLE, we=0 from the reset edge on, sum=0. A following start reloads from a=0 with a fresh checksum.
- Restart from DONE: after a complete load, start again -> done drops, sum clears, first we has a=0. A start pulse during LOAD leaves addr and sum undisturbed.

Source files
------------

// File: rtl/mem_loader.sv
// rtl/mem_loader.sv - byte-stream to sequential memory-image write port loader
//
// Purpose: takes bytes from a valid/ready stream (SD, SPI flash or UART front
// end) and writes them to consecutive addresses of a KB-kilobyte memory image.
// Each write is issued only on a clock where ce=1. The loader reports a running
// modulo-256 checksum and raises done after the last address has been written.
//
// Ports:
//   clock     in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   ce        in   write-pacing enable
//   start     in   begin a load (honoured in IDLE or DONE only)
//   in_valid  in   in_data holds a byte
//   in_data   in   [7:0] stream byte
//   in_ready  out  loader can take a byte this cycle
//   a         out  [AW-1:0] registered memory write address
//   d         out  [7:0] registered memory write data
//   we        out  registered one-clock memory write strobe
//   busy      out  state is LOAD
//   done      out  state is DONE
//   sum       out  [7:0] modulo-256 sum of bytes written since last start
module mem_loader #(
  parameter int KB = 16,
  parameter int AW = $clog2(KB * 1024)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ce,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic [AW-1:0] a,
  output logic [7:0]    d,
  output logic          we,
  output logic          busy,
  output logic          done,
  output logic [7:0]    sum
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(KB * 1024 - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    buf_q, buf_d;
  logic          full_q, full_d;
  logic [7:0]    sum_q, sum_d;
  logic [AW-1:0] a_q, a_d;
  logic [7:0]    d_q, d_d;
  logic          we_q, we_d;

  logic accept;
  logic write;

  // Ready depends on registered state only, so a source may legally wait for
  // ready before raising valid without creating a combinational loop.
  assign in_ready = (state_q == S_LOAD) && !full_q;
  assign accept   = in_valid && in_ready;
  assign write    = (state_q == S_LOAD) && full_q && ce;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    buf_d   = buf_q;
    full_d  = full_q;
    sum_d   = sum_q;
    a_d     = a_q;
    d_d     = d_q;
    we_d    = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          addr_d  = '0;
          sum_d   = 8'd0;
          full_d  = 1'b0;
        end
      end
      S_LOAD: begin
        // Write and accept are mutually exclusive: accept needs full=0,
        // write needs full=1, which caps throughput at one byte per 2 clocks.
        if (write) begin
          we_d   = 1'b1;
          a_d    = addr_q;
          d_d    = buf_q;
          sum_d  = sum_q + buf_q;
          full_d = 1'b0;
          addr_d = addr_q + 1'b1;
          if (addr_q == LAST_ADDR) begin
            state_d = S_DONE;
          end
        end else if (accept) begin
          buf_d  = in_data;
          full_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      buf_q   <= 8'd0;
      full_q  <= 1'b0;
      sum_q   <= 8'd0;
      a_q     <= '0;
      d_q     <= 8'd0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
      full_q  <= full_d;
      sum_q   <= sum_d;
      a_q     <= a_d;
      d_q     <= d_d;
      we_q    <= we_d;
    end
  end

  assign a    = a_q;
  assign d    = d_q;
  assign we   = we_q;
  assign sum  = sum_q;
  assign busy = (state_q == S_LOAD);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_mem_loader.sv
// tb/tb_mem_loader.sv - self-checking bench for mem_loader (KB=1)
module tb_mem_loader;

  localparam int KB = 1;
  localparam int AW = 10;
  localparam int NB = KB * 1024;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          ce = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'd0;
  logic          in_ready;
  logic [AW-1:0] a;
  logic [7:0]    d;
  logic          we;
  logic          busy;
  logic          done;
  logic [7:0]    sum;

  int checks = 0;
  int errors = 0;

  mem_loader #(.KB(KB)) dut (
    .clock    (clock),
    .reset    (reset),
    .ce       (ce),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .a        (a),
    .d        (d),
    .we       (we),
    .busy     (busy),
    .done     (done),
    .sum      (sum)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic       st;
    logic       cen;
    logic       vld;
    logic [7:0] din;
    logic       rdy;
    logic       wr;
    logic [9:0] adr;
    logic [7:0] dat;
    logic       bsy;
    logic       dne;
    logic [7:0] chk;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start();
    start    = 1'b1;
    in_valid = 1'b0;
    ce       = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_done", done, 0);
    check("start_sum", sum, 0);
    check("start_we", we, 0);
    check("start_ready", in_ready, 1);
  endtask

  // Streams nbytes of pattern (i*mult+add) from address 0. ce is high one
  // clock in ce_div; rnd_valid randomly withholds in_valid.
  task automatic stream(input int nbytes, input int mult, input int add,
                        input int ce_div, input bit rnd_valid, input bit expect_done);
    int idx = 0;
    int nw = 0;
    int msum = 0;
    bit acc;
    bit ce_now;
    bit prev_we = 0;
    int budget = nbytes * 8 + 100;
    for (int cyc = 0; cyc < budget; cyc++) begin
      in_data  = 8'((idx * mult + add) & 8'hFF);
      in_valid = (idx < nbytes) && (rnd_valid ? ($urandom_range(0, 1) == 1) : 1'b1);
      ce       = ((cyc % ce_div) == 0);
      acc      = in_valid && in_ready;
      ce_now   = ce;
      tick();
      if (acc) idx++;
      if (we) begin
        check("we_on_ce", 32'(ce_now), 1);
        check("we_gap", 32'(prev_we), 0);
        check("wr_addr", 32'(a), nw);
        check("wr_data", 32'(d), (nw * mult + add) & 8'hFF);
        msum = (msum + ((nw * mult + add) & 8'hFF)) & 8'hFF;
        nw++;
      end
      prev_we = we;
      if (nw == nbytes) break;
      check("ready_model", 32'(in_ready), 32'(busy && !(idx > nw)));
    end
    in_valid = 1'b0;
    check("write_count", nw, nbytes);
    check("stream_sum", sum, msum);
    check("end_done", done, 32'(expect_done));
    check("end_busy", busy, 32'(!expect_done));
  endtask

  initial begin
    void'($urandom(32'd1234));

    //            rst st  ce  vld din     rdy we  a       d      bsy dne sum
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 10'd0, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 10'd0, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 10'd0, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 10'd0, 8'h00, 1'b1, 1'b0, 8'h00};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 10'd0, 8'h00, 1'b1, 1'b0, 8'h00};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 10'd0, 8'h11, 1'b1, 1'b0, 8'h11};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 10'd0, 8'h11, 1'b1, 1'b0, 8'h11};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 10'd0, 8'h11, 1'b1, 1'b0, 8'h11};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 10'd0, 8'h11, 1'b1, 1'b0, 8'h11};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h33, 1'b1, 1'b1, 10'd1, 8'h22, 1'b1, 1'b0, 8'h33};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 10'd1, 8'h22, 1'b1, 1'b0, 8'h33};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0, 10'd1, 8'h22, 1'b1, 1'b0, 8'h33};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 10'd2, 8'hF0, 1'b1, 1'b0, 8'h23};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h44, 1'b0, 1'b0, 10'd0, 8'h00, 1'b0, 1'b0, 8'h00};

    for (int i = 0; i < 14; i++) begin
      reset    = vecs[i].rst;
      start    = vecs[i].st;
      ce       = vecs[i].cen;
      in_valid = vecs[i].vld;
      in_data  = vecs[i].din;
      tick();
      check($sformatf("v%0d_ready", i), in_ready, vecs[i].rdy);
      check($sformatf("v%0d_we", i), we, vecs[i].wr);
      check($sformatf("v%0d_a", i), a, vecs[i].adr);
      check($sformatf("v%0d_d", i), d, vecs[i].dat);
      check($sformatf("v%0d_busy", i), busy, vecs[i].bsy);
      check($sformatf("v%0d_done", i), done, vecs[i].dne);
      check($sformatf("v%0d_sum", i), sum, vecs[i].chk);
    end
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    tick();

    // Full 1 KB image, ce always high.
    do_start();
    stream(NB, 7, 0, 1, 1'b0, 1'b1);
    check("full_ready_after", in_ready, 0);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("done_hold_we", we, 0);
      check("done_hold_ready", in_ready, 0);
      check("done_hold_done", done, 1);
    end
    in_valid = 1'b0;

    // Restart from DONE with ce high one clock in four.
    do_start();
    stream(64, 3, 9, 4, 1'b0, 1'b0);

    // Return to IDLE, then reset in the middle of a load with a byte buffered.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    do_start();
    stream(10, 5, 1, 1, 1'b0, 1'b0);
    ce       = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h77;
    tick();
    check("buffered_ready", in_ready, 0);
    check("buffered_we", we, 0);
    reset = 1'b1;
    ce    = 1'b1;
    tick();
    check("mid_rst_we", we, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_sum", sum, 0);
    check("mid_rst_ready", in_ready, 0);
    reset    = 1'b0;
    in_valid = 1'b0;
    tick();
    check("idle_we", we, 0);

    // Fresh load after reset with random source stalls.
    do_start();
    stream(100, 13, 5, 1, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
